axi_lite_modport: RTL and testbench



---
 rtl/axi_lite_pkg.sv | 13 +
 rtl/axi_lite_regfile.sv | 31 +++
 rtl/axi_lite_modport.sv | 124 ++++++++++++
 tb/tb_axi_lite_modport.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite widths and response encoding
`timescale 1ns/1ps
package axi_lite_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  // EXOKAY (2'b01) and DECERR (2'b11) are reserved and never produced
  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;
endpackage

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - byte-enabled 32-bit register file, one write port, one async read port
`timescale 1ns/1ps
module axi_lite_regfile
  import axi_lite_pkg::*;
#(
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  localparam int               IW        = $clog2(NUM_REGS)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic [IW-1:0]     i_widx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  input  logic [IW-1:0]     i_ridx,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_REGS; i++) r_mem[i] <= RESET_VAL;
    end else if (i_we) begin
      for (int b = 0; b < STRB_W; b++)
        if (i_wstrb[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_ridx];
endmodule

// File: rtl/axi_lite_modport.sv
// rtl/axi_lite_modport.sv - AXI4-Lite slave endpoint backed by a register file
`timescale 1ns/1ps
module axi_lite_modport
  import axi_lite_pkg::*;
#(
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              ACLK_i,
  input  logic              ARESET_i,
  input  logic [ADDR_W-1:0] ARADDR_i,
  input  logic              ARVALID_i,
  output logic              ARREADY_o,
  output logic [DATA_W-1:0] RDATA_o,
  output logic [1:0]        RRESP_o,
  output logic              RVALID_o,
  input  logic              RREADY_i,
  input  logic [ADDR_W-1:0] AWADDR_i,
  input  logic              AWVALID_i,
  output logic              AWREADY_o,
  input  logic [DATA_W-1:0] WDATA_i,
  input  logic [STRB_W-1:0] WSTRB_i,
  input  logic              WVALID_i,
  output logic              WREADY_o,
  output logic [1:0]        BRESP_o,
  output logic              BVALID_o,
  input  logic              BREADY_i
);
  localparam int IW = $clog2(NUM_REGS);

  logic              r_aw_held;
  logic [ADDR_W-1:0] r_aw_addr;
  logic              r_w_held;
  logic [DATA_W-1:0] r_w_data;
  logic [STRB_W-1:0] r_w_strb;
  logic              r_bvalid;
  resp_t             r_bresp;
  logic              r_rvalid;
  logic [DATA_W-1:0] r_rdata;
  resp_t             r_rresp;

  logic              w_aw_hs, w_w_hs, w_ar_hs, w_commit;
  logic [ADDR_W-1:0] w_wr_addr;
  logic [DATA_W-1:0] w_wr_data;
  logic [STRB_W-1:0] w_wr_strb;
  logic              w_wr_ok, w_rd_ok;
  logic [DATA_W-1:0] w_rd_data;
  logic              w_unused_lsb;

  assign AWREADY_o = !ARESET_i && !r_aw_held && !r_bvalid;
  assign WREADY_o  = !ARESET_i && !r_w_held && !r_bvalid;
  assign ARREADY_o = !ARESET_i && !r_rvalid;

  assign w_aw_hs = AWVALID_i && AWREADY_o;
  assign w_w_hs  = WVALID_i && WREADY_o;
  assign w_ar_hs = ARVALID_i && ARREADY_o;

  // A beat counts as available if latched earlier or handshaking this edge
  assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
  assign w_wr_addr = r_aw_held ? r_aw_addr : AWADDR_i;
  assign w_wr_data = r_w_held ? r_w_data : WDATA_i;
  assign w_wr_strb = r_w_held ? r_w_strb : WSTRB_i;
  assign w_wr_ok   = (w_wr_addr[ADDR_W-1:IW+2] == '0);
  assign w_rd_ok   = (ARADDR_i[ADDR_W-1:IW+2] == '0);
  assign w_unused_lsb = &{1'b0, w_wr_addr[1:0], ARADDR_i[1:0]};

  axi_lite_regfile #(.NUM_REGS(NUM_REGS), .RESET_VAL(RESET_VAL)) u_regfile (
    .i_clk   (ACLK_i),
    .i_rst   (ARESET_i),
    .i_we    (w_commit && w_wr_ok),
    .i_widx  (w_wr_addr[IW+1:2]),
    .i_wdata (w_wr_data),
    .i_wstrb (w_wr_strb),
    .i_ridx  (ARADDR_i[IW+1:2]),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge ACLK_i) begin
    if (ARESET_i) begin
      r_aw_held <= 1'b0;
      r_aw_addr <= '0;
      r_w_held  <= 1'b0;
      r_w_data  <= '0;
      r_w_strb  <= '0;
      r_bvalid  <= 1'b0;
      r_bresp   <= OKAY;
      r_rvalid  <= 1'b0;
      r_rdata   <= '0;
      r_rresp   <= OKAY;
    end else begin
      if (w_commit) begin
        r_aw_held <= 1'b0;
        r_w_held  <= 1'b0;
        r_bvalid  <= 1'b1;
        r_bresp   <= w_wr_ok ? OKAY : SLVERR;
      end else begin
        if (w_aw_hs) begin
          r_aw_held <= 1'b1;
          r_aw_addr <= AWADDR_i;
        end
        if (w_w_hs) begin
          r_w_held <= 1'b1;
          r_w_data <= WDATA_i;
          r_w_strb <= WSTRB_i;
        end
        if (r_bvalid && BREADY_i) r_bvalid <= 1'b0;
      end
      // Read samples the pre-edge register value, so a same-edge write is not seen
      if (w_ar_hs) begin
        r_rvalid <= 1'b1;
        r_rdata  <= w_rd_ok ? w_rd_data : '0;
        r_rresp  <= w_rd_ok ? OKAY : SLVERR;
      end else if (r_rvalid && RREADY_i) begin
        r_rvalid <= 1'b0;
      end
    end
  end

  assign BVALID_o = r_bvalid;
  assign BRESP_o  = r_bresp;
  assign RVALID_o = r_rvalid;
  assign RDATA_o  = r_rdata;
  assign RRESP_o  = r_rresp;
endmodule

// File: tb/tb_axi_lite_modport.sv
// tb/tb_axi_lite_modport.sv - scoreboard bench for axi_lite_modport
`timescale 1ns/1ps
module tb_axi_lite_modport;
  logic        ACLK_i = 1'b0;
  logic        ARESET_i = 1'b1;
  logic [31:0] ARADDR_i = '0;
  logic        ARVALID_i = 1'b0;
  logic        ARREADY_o;
  logic [31:0] RDATA_o;
  logic [1:0]  RRESP_o;
  logic        RVALID_o;
  logic        RREADY_i = 1'b1;
  logic [31:0] AWADDR_i = '0;
  logic        AWVALID_i = 1'b0;
  logic        AWREADY_o;
  logic [31:0] WDATA_i = '0;
  logic [3:0]  WSTRB_i = '0;
  logic        WVALID_i = 1'b0;
  logic        WREADY_o;
  logic [1:0]  BRESP_o;
  logic        BVALID_o;
  logic        BREADY_i = 1'b1;

  always #5 ACLK_i = ~ACLK_i;

  axi_lite_modport #(.NUM_REGS(16), .RESET_VAL(32'h0)) dut (
    .ACLK_i(ACLK_i), .ARESET_i(ARESET_i),
    .ARADDR_i(ARADDR_i), .ARVALID_i(ARVALID_i), .ARREADY_o(ARREADY_o),
    .RDATA_o(RDATA_o), .RRESP_o(RRESP_o), .RVALID_o(RVALID_o), .RREADY_i(RREADY_i),
    .AWADDR_i(AWADDR_i), .AWVALID_i(AWVALID_i), .AWREADY_o(AWREADY_o),
    .WDATA_i(WDATA_i), .WSTRB_i(WSTRB_i), .WVALID_i(WVALID_i), .WREADY_o(WREADY_o),
    .BRESP_o(BRESP_o), .BVALID_o(BVALID_o), .BREADY_i(BREADY_i)
  );

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
  } rexp_t;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] mdl [16];
  logic [1:0]  bq [$];
  rexp_t       rq [$];
  int          b_mode = 1;   // 0 hold low, 1 hold high, 2 random
  int          r_mode = 1;
  logic [31:0] old_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic bit in_range(input logic [31:0] a);
    return a < 32'd64;
  endfunction

  always @(posedge ACLK_i) begin
    #2;
    BREADY_i = (b_mode == 2) ? 1'($urandom % 2) : (b_mode == 1);
    RREADY_i = (r_mode == 2) ? 1'($urandom % 2) : (r_mode == 1);
  end

  always @(negedge ACLK_i) begin
    if (!ARESET_i) begin
      if (BVALID_o && BREADY_i) begin
        if (bq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_b: got resp %h expected none", BRESP_o);
        end else chk("bresp", 32'(BRESP_o), 32'(bq.pop_front()));
      end
      if (RVALID_o && RREADY_i) begin
        if (rq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_r: got data %h expected none", RDATA_o);
        end else begin
          rexp_t e;
          e = rq.pop_front();
          chk("rresp", 32'(RRESP_o), 32'(e.resp));
          chk("rdata", RDATA_o, e.data);
        end
      end
    end
  end

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
    int cyc = 0;
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    bq.push_back(in_range(a) ? 2'b00 : 2'b10);
    if (in_range(a))
      for (int b = 0; b < 4; b++) if (s[b]) mdl[a[5:2]][8*b +: 8] = d[8*b +: 8];
    AWADDR_i = a; WDATA_i = d; WSTRB_i = s;
    while (!(aw_done && w_done) && cyc < 64) begin
      AWVALID_i = !aw_done && (cyc >= (lead > 0 ? lead : 0));
      WVALID_i  = !w_done && (cyc >= (lead < 0 ? -lead : 0));
      @(negedge ACLK_i);
      aw_hs = AWVALID_i && AWREADY_o;
      w_hs  = WVALID_i && WREADY_o;
      @(posedge ACLK_i); #1;
      aw_done |= aw_hs; w_done |= w_hs; cyc++;
    end
    AWVALID_i = 0; WVALID_i = 0;
    if (!(aw_done && w_done)) begin
      n_cmp++; n_bad++;
      $display("FAIL wr_timeout: got aw=%0d w=%0d expected both accepted", aw_done, w_done);
    end
  endtask

  task automatic rd(input logic [31:0] a);
    int cyc = 0;
    bit hs = 0;
    ARADDR_i = a; ARVALID_i = 1;
    while (!hs && cyc < 64) begin
      @(negedge ACLK_i);
      hs = ARREADY_o;
      if (hs) rq.push_back('{resp: in_range(a) ? 2'b00 : 2'b10,
                             data: in_range(a) ? mdl[a[5:2]] : 32'h0});
      @(posedge ACLK_i); #1;
      cyc++;
    end
    ARVALID_i = 0;
    if (!hs) begin
      n_cmp++; n_bad++;
      $display("FAIL rd_timeout: got no AR handshake expected one");
    end
  endtask

  task automatic dump();
    for (int i = 0; i < 16; i++) rd(32'(i * 4));
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    repeat (3) @(posedge ACLK_i);
    @(negedge ACLK_i);
    chk("rst_readys", {29'h0, ARREADY_o, AWREADY_o, WREADY_o}, 32'h0);
    chk("rst_valids", {30'h0, BVALID_o, RVALID_o}, 32'h0);
    chk("rst_rdata", RDATA_o, 32'h0);
    chk("rst_resps", {28'h0, BRESP_o, RRESP_o}, 32'h0);
    @(posedge ACLK_i); #1 ARESET_i = 0;
    @(negedge ACLK_i);
    chk("post_rst_readys", {29'h0, ARREADY_o, AWREADY_o, WREADY_o}, 32'h7);
    @(posedge ACLK_i); #1;

    wr(32'h04, 32'hA5A5_1234, 4'hF, 0);
    chk("b_next_cycle", 32'(BVALID_o), 32'h1);
    chk("b_okay", 32'(BRESP_o), 32'h0);
    rd(32'h04);

    // W leads AW by three cycles
    bq.push_back(2'b00);
    mdl[2] = 32'h00FF_00FF;
    WDATA_i = 32'hFFFF_FFFF; WSTRB_i = 4'b0101; WVALID_i = 1;
    @(posedge ACLK_i); #1 WVALID_i = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK_i);
      chk("w_held_wready", 32'(WREADY_o), 32'h0);
      chk("w_held_no_b", 32'(BVALID_o), 32'h0);
      @(posedge ACLK_i); #1;
    end
    AWADDR_i = 32'h08; AWVALID_i = 1;
    @(posedge ACLK_i); #1 AWVALID_i = 0;
    chk("w_first_b", 32'(BVALID_o), 32'h1);
    rd(32'h08);
    chk("w_first_model", mdl[2], 32'h00FF_00FF);

    wr(32'h40, 32'hDEAD_BEEF, 4'hF, -1);
    dump();
    rd(32'h40);

    // B back-pressure holds the write channel
    b_mode = 0;
    wr(32'h0C, 32'h1357_9BDF, 4'hF, 0);
    AWADDR_i = 32'h10; AWVALID_i = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK_i);
      chk("bp_bvalid", 32'(BVALID_o), 32'h1);
      chk("bp_bresp", 32'(BRESP_o), 32'h0);
      chk("bp_readys", {30'h0, AWREADY_o, WREADY_o}, 32'h0);
      @(posedge ACLK_i); #1;
    end
    b_mode = 1;
    wr(32'h10, 32'h2468_ACE0, 4'b0011, 0);

    // Read pending while the same register is rewritten
    wr(32'h00, 32'h1111_2222, 4'hF, 0);
    old_val = mdl[0];
    r_mode = 0;
    rd(32'h00);
    wr(32'h00, 32'h3333_4444, 4'hF, 1);
    repeat (2) begin
      @(negedge ACLK_i);
      chk("rpend_rdata", RDATA_o, 32'h1111_2222);
      chk("rpend_rvalid", 32'(RVALID_o), 32'h1);
      @(posedge ACLK_i); #1;
    end
    r_mode = 1;
    rd(32'h00);
    chk("rpend_old", old_val, 32'h1111_2222);

    // Reset with AW held and a read response pending
    repeat (3) @(posedge ACLK_i); #1;
    r_mode = 0;
    rd(32'h04);
    AWADDR_i = 32'h14; AWVALID_i = 1;
    @(posedge ACLK_i); #1 AWVALID_i = 0;
    ARESET_i = 1;
    rq.delete();
    bq.delete();
    @(negedge ACLK_i);
    chk("mid_rst_readys", {29'h0, ARREADY_o, AWREADY_o, WREADY_o}, 32'h0);
    @(posedge ACLK_i); #1;
    @(negedge ACLK_i);
    chk("mid_rst_valids", {30'h0, BVALID_o, RVALID_o}, 32'h0);
    chk("mid_rst_readys2", {29'h0, ARREADY_o, AWREADY_o, WREADY_o}, 32'h0);
    @(posedge ACLK_i); #1 ARESET_i = 0; r_mode = 1;
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
    @(negedge ACLK_i);
    chk("rel_readys", {29'h0, ARREADY_o, AWREADY_o, WREADY_o}, 32'h7);
    @(posedge ACLK_i); #1;
    wr(32'h18, 32'hFFFF_FFFF, 4'hF, 1);
    dump();

    b_mode = 2; r_mode = 2;
    for (int it = 0; it < 80; it++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 19) << 2) | ($urandom & 32'h3);
      if ($urandom % 2) wr(a, $urandom, 4'($urandom), $urandom_range(0, 4) - 2);
      else rd(a);
    end

    b_mode = 1; r_mode = 1;
    for (int i = 0; i < 100 && (bq.size() != 0 || rq.size() != 0); i++) @(posedge ACLK_i);
    chk("drain_b", 32'(bq.size()), 32'h0);
    chk("drain_r", 32'(rq.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
